// File: rtl/fp_div_issue.sv
// fp_div_issue
// Request queue and issue controller placed directly in front of fp_div.
// Tagged divide requests arrive on a valid/ready port and are buffered in a
// DEPTH-entry FIFO. The head entry is issued to the divider with a one-cycle
// start pulse. Its operands are held on div_op_a/div_op_b until the result is
// captured. Results leave in request order, with their tags, on a valid/ready
// output port.
//
// Ports
//   clk, rst               clock; asynchronous active-high reset
//   in_valid/in_ready      request handshake (in_ready = count < DEPTH)
//   in_op_a/in_op_b/in_tag dividend, divisor, request tag
//   div_start              one-cycle start pulse to the divider
//   div_op_a/div_op_b      head operands during START/WAIT, otherwise 0
//   div_done/div_res       divider done level and result
//   out_valid/out_ready    result handshake
//   out_res/out_tag        captured quotient and its tag
//   count                  FIFO occupancy
//   busy                   controller not idle, or queue not empty
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | nothing in flight; leave as soon as the queue holds a request
// START  | div_start high for this single cycle; head operands driven
// WAIT   | operands held; capture div_res and pop when div_done is seen
// OUT    | result held on out_*; no new issue until it is accepted

module fp_div_issue #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 4,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          in_op_a,
   input  logic [DATA_W-1:0]          in_op_b,
   input  logic [TAG_W-1:0]           in_tag,
   output logic                       div_start,
   output logic [DATA_W-1:0]          div_op_a,
   output logic [DATA_W-1:0]          div_op_b,
   input  logic                       div_done,
   input  logic [DATA_W-1:0]          div_res,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_res,
   output logic [TAG_W-1:0]           out_tag,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       busy
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [DATA_W-1:0] mem_a   [DEPTH];
   logic [DATA_W-1:0] mem_b   [DEPTH];
   logic [TAG_W-1:0]  mem_tag [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;

   logic push, pop, op_active;

   // Registered count only, so a pop in a full cycle does not open in_ready.
   assign in_ready = (count < CNT_W'(DEPTH));
   assign push     = in_valid & in_ready;
   // div_done idles high, so it is only meaningful once we are in WAIT.
   assign pop      = (state == S_WAIT) & div_done;

   // Payload storage carries no reset; validity is tracked by count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr]   <= in_op_a;
         mem_b[wr_ptr]   <= in_op_b;
         mem_tag[wr_ptr] <= in_tag;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         out_res <= '0;
         out_tag <= '0;
      end else begin
         state <= state_nxt;
         count <= count + CNT_W'(push) - CNT_W'(pop);
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop) begin
            rd_ptr  <= rd_ptr + PTR_W'(1);
            out_res <= div_res;
            out_tag <= mem_tag[rd_ptr];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      div_start = 1'b0;
      out_valid = 1'b0;
      op_active = 1'b0;
      case (state)
         S_IDLE: begin
            if (count != '0) state_nxt = S_START;
         end
         S_START: begin
            div_start = 1'b1;
            op_active = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            op_active = 1'b1;
            if (div_done) state_nxt = S_OUT;
         end
         S_OUT: begin
            out_valid = 1'b1;
            // count already reflects the pop made at capture.
            if (out_ready) state_nxt = (count != '0) ? S_START : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign div_op_a = op_active ? mem_a[rd_ptr] : '0;
   assign div_op_b = op_active ? mem_b[rd_ptr] : '0;
   assign busy     = (state != S_IDLE) || (count != '0);

endmodule

// File: tb/tb_fp_div_issue.sv
// Directed bench for fp_div_issue. A small behavioural divider model answers
// each div_start. x/1.0 returns x after dm_lat cycles. 0/0 returns a quiet NaN
// after one cycle.
module tb_fp_div_issue;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_op_a, in_op_b;
   logic [3:0]  in_tag;
   logic        div_start;
   logic [31:0] div_op_a, div_op_b;
   logic        div_done;
   logic [31:0] div_res;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_res;
   logic [3:0]  out_tag;
   logic [2:0]  count;
   logic        busy;

   int total = 0;
   int bad   = 0;

   fp_div_issue #(.DATA_W(32), .TAG_W(4), .DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op_a(in_op_a), .in_op_b(in_op_b), .in_tag(in_tag),
      .div_start(div_start), .div_op_a(div_op_a), .div_op_b(div_op_b),
      .div_done(div_done), .div_res(div_res),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_res(out_res), .out_tag(out_tag),
      .count(count), .busy(busy)
   );

   always #5 clk = ~clk;

   // divider model
   logic        dm_done = 1'b1;
   logic [31:0] dm_res  = '0;
   logic [31:0] dm_a    = '0;
   int          dm_rem  = 0;
   int          dm_lat  = 5;

   assign div_done = dm_done;
   assign div_res  = dm_res;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         dm_done <= 1'b1;
         dm_rem  <= 0;
      end else if (div_start) begin
         if (div_op_b == 32'h0) begin
            dm_done <= 1'b1;
            dm_res  <= 32'h7FC00000;
         end else begin
            dm_done <= 1'b0;
            dm_rem  <= dm_lat - 1;
            dm_a    <= div_op_a;
         end
      end else if (!dm_done) begin
         if (dm_rem == 1) begin
            dm_done <= 1'b1;
            dm_res  <= dm_a;
         end else begin
            dm_rem <= dm_rem - 1;
         end
      end
   end

   // result scoreboard
   logic [31:0] sb_res [$];
   logic [3:0]  sb_tag [$];

   always @(posedge clk) begin
      if (!rst && out_valid && out_ready) begin
         sb_res.push_back(out_res);
         sb_tag.push_back(out_tag);
      end
   end

   // monitors: operand stability during an operation, full-queue behaviour
   int          stab_bad  = 0;
   int          full_bad  = 0;
   bit          saw_full  = 0;
   bit          saw_4to3  = 0;
   bit          in_op     = 0;
   logic [2:0]  prev_cnt  = '0;
   logic [31:0] op_a_l, op_b_l;

   always @(negedge clk) begin
      if (rst) begin
         in_op    = 0;
         prev_cnt = '0;
      end else begin
         if (count == 3'd4) saw_full = 1;
         if (count == 3'd4 && in_ready) full_bad++;
         if (prev_cnt == 3'd4 && count == 3'd3) saw_4to3 = 1;
         prev_cnt = count;
         if (div_start) begin
            op_a_l = div_op_a;
            op_b_l = div_op_b;
            in_op  = 1;
         end else if (in_op && !out_valid) begin
            if (div_op_a !== op_a_l || div_op_b !== op_b_l) stab_bad++;
         end else begin
            in_op = 0;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_start(input string name);
      int n = 0;
      while (!div_start && n < 200) begin
         tick();
         n++;
      end
      chk(name, div_start, 1'b1);
   endtask

   task automatic wait_out(input string name);
      int n = 0;
      while (!out_valid && n < 200) begin
         tick();
         n++;
      end
      chk(name, out_valid, 1'b1);
   endtask

   task automatic push1(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
      in_valid = 1'b1;
      in_op_a  = a;
      in_op_b  = b;
      in_tag   = t;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic check_reset_vals(input string pfx);
      chk({pfx, "_in_ready"},  in_ready,  1'b1);
      chk({pfx, "_div_start"}, div_start, 1'b0);
      chk({pfx, "_div_op_a"},  div_op_a,  32'h0);
      chk({pfx, "_div_op_b"},  div_op_b,  32'h0);
      chk({pfx, "_out_valid"}, out_valid, 1'b0);
      chk({pfx, "_out_res"},   out_res,   32'h0);
      chk({pfx, "_out_tag"},   out_tag,   4'h0);
      chk({pfx, "_count"},     count,     3'd0);
      chk({pfx, "_busy"},      busy,      1'b0);
   endtask

   logic [31:0] exp_a [6];

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_op_a   = '0;
      in_op_b   = '0;
      in_tag    = '0;
      out_ready = 1'b1;
      exp_a[0] = 32'h3F800000; exp_a[1] = 32'h40000000; exp_a[2] = 32'h40400000;
      exp_a[3] = 32'h40800000; exp_a[4] = 32'h40A00000; exp_a[5] = 32'h40C00000;

      // reset values
      tick();
      tick();
      check_reset_vals("rst");
      rst = 1'b0;
      tick();

      // single normal request, L=5, stale div_done during START
      dm_lat = 5;
      push1(32'h40400000, 32'h3F800000, 4'd3);          // now at C+1
      chk("t1_c1_start", div_start, 1'b0);
      chk("t1_c1_count", count, 3'd1);
      chk("t1_c1_busy",  busy, 1'b1);
      tick();                                           // T = C+2
      chk("t1_T_start", div_start, 1'b1);
      chk("t1_T_op_a",  div_op_a, 32'h40400000);
      chk("t1_T_op_b",  div_op_b, 32'h3F800000);
      chk("t1_T_done_stale", div_done, 1'b1);
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk($sformatf("t1_T%0d_out_valid", i), out_valid, 1'b0);
      end
      tick();                                           // T+6
      chk("t1_T6_out_valid", out_valid, 1'b1);
      chk("t1_T6_out_res",   out_res, 32'h40400000);
      chk("t1_T6_out_tag",   out_tag, 4'd3);
      chk("t1_T6_count",     count, 3'd0);
      tick();
      chk("t1_idle_out_valid", out_valid, 1'b0);
      chk("t1_idle_busy",      busy, 1'b0);

      // special case: 0/0 completes one cycle after start
      push1(32'h0, 32'h0, 4'd7);
      tick();
      chk("t2_T_start", div_start, 1'b1);
      tick();
      chk("t2_T1_out_valid", out_valid, 1'b0);
      tick();
      chk("t2_T2_out_valid", out_valid, 1'b1);
      chk("t2_T2_out_res",   out_res, 32'h7FC00000);
      chk("t2_T2_out_tag",   out_tag, 4'd7);
      tick();
      tick();

      // six back-to-back requests through a 4-deep queue
      sb_res.delete();
      sb_tag.delete();
      dm_lat = 3;
      for (int i = 0; i < 6; i++) begin
         bit acc;
         int n = 0;
         in_valid = 1'b1;
         in_op_a  = exp_a[i];
         in_op_b  = 32'h3F800000;
         in_tag   = 4'(i);
         acc = in_ready;
         tick();
         while (!acc && n < 200) begin
            acc = in_ready;
            tick();
            n++;
         end
      end
      in_valid = 1'b0;
      begin
         int n = 0;
         while (sb_tag.size() < 6 && n < 400) begin
            tick();
            n++;
         end
      end
      chk("t3_result_count", sb_tag.size(), 6);
      for (int i = 0; i < 6; i++) begin
         if (i < sb_tag.size()) begin
            chk($sformatf("t3_tag%0d", i), sb_tag[i], 4'(i));
            chk($sformatf("t3_res%0d", i), sb_res[i], exp_a[i]);
         end
      end
      chk("t3_saw_full",   saw_full, 1'b1);
      chk("t3_full_ready", full_bad, 0);
      chk("t3_full_pop",   saw_4to3, 1'b1);
      chk("t3_op_stable",  stab_bad, 0);
      tick();
      tick();
      chk("t3_idle_busy", busy, 1'b0);

      // output stall with two requests queued
      out_ready = 1'b0;
      dm_lat = 3;
      in_valid = 1'b1;
      in_op_b  = 32'h3F800000;
      in_op_a  = 32'h41000000; in_tag = 4'd8;  tick();
      in_op_a  = 32'h41100000; in_tag = 4'd9;  tick();
      in_op_a  = 32'h41200000; in_tag = 4'd10; tick();
      in_valid = 1'b0;
      wait_out("t4_out_timeout");
      chk("t4_count", count, 3'd2);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("t4_stall%0d_valid", i), out_valid, 1'b1);
         chk($sformatf("t4_stall%0d_start", i), div_start, 1'b0);
         chk($sformatf("t4_stall%0d_res", i),   out_res, 32'h41000000);
         chk($sformatf("t4_stall%0d_tag", i),   out_tag, 4'd8);
      end
      out_ready = 1'b1;                                 // handshake cycle H
      tick();
      chk("t4_H1_start", div_start, 1'b1);
      chk("t4_H1_out_valid", out_valid, 1'b0);
      chk("t4_H1_op_a", div_op_a, 32'h41100000);
      begin
         int n = 0;
         while (busy && n < 200) begin
            tick();
            n++;
         end
      end
      chk("t4_drain_busy", busy, 1'b0);
      chk("t4_out_tag_last", out_tag, 4'd10);

      // reset in the middle of an operation with two queued
      dm_lat = 10;
      in_valid = 1'b1;
      in_op_b  = 32'h3F800000;
      in_op_a  = 32'h41300000; in_tag = 4'd1; tick();
      in_op_a  = 32'h41400000; in_tag = 4'd2; tick();
      in_op_a  = 32'h41500000; in_tag = 4'd4; tick();
      in_valid = 1'b0;
      wait_start("t5_start_timeout");
      tick();
      tick();
      tick();                                           // T+3
      rst = 1'b1;
      #1;
      check_reset_vals("t5_async");
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("t5_post%0d_start", i), div_start, 1'b0);
         chk($sformatf("t5_post%0d_count", i), count, 3'd0);
      end
      dm_lat = 2;
      push1(32'h40A00000, 32'h3F800000, 4'd13);
      wait_out("t5_out_timeout");
      chk("t5_new_tag", out_tag, 4'd13);
      chk("t5_new_res", out_res, 32'h40A00000);
      tick();
      tick();
      chk("t5_idle_busy", busy, 1'b0);
      chk("final_op_stable", stab_bad, 0);
      chk("final_full_ready", full_bad, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fp_div_issue.md
# fp_div_issue

Request queue and issue controller that sits directly upstream of `fp_div`. It accepts tagged divide requests on a valid/ready interface and buffers them in a DEPTH-entry FIFO. It issues them one at a time to the divider's start/done port, holding operands stable for the whole operation. Each result is returned with its tag on a valid/ready output, in request order.

## Interface
- `DATA_W`, 32, operand/result width (matches divider).
- `TAG_W`, 4, request tag width.
- `DEPTH`, 4, FIFO entries; power of 2, ≥2.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  `count < DEPTH`.
- `in_op_a`, `in_op_b`  in  DATA_W  dividend, divisor.
- `in_tag`  in  TAG_W  request tag.
- `div_start`  out  1  one-cycle start pulse to divider.
- `div_op_a`, `div_op_b`  out  DATA_W  FIFO head operands in START/WAIT, else 0.
- `div_done`  in  1  divider done level.
- `div_res`  in  DATA_W  divider result, valid while `div_done`=1.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer accepts.
- `out_res`  out  DATA_W  quotient.
- `out_tag`  out  TAG_W  tag of that quotient.
- `count`  out  $clog2(DEPTH+1)  FIFO occupancy.
- `busy`  out  1  state ≠ IDLE or `count` ≠ 0.

## Operation
- FIFO
  - Push on `in_valid & in_ready` at the clock edge.
  - Pop only at result capture.
  - `in_ready` depends on the registered `count` only: when full with a pop in the same cycle, `in_ready` stays 0.
  - Pointers wrap modulo DEPTH.
  - Storage is not reset.
- FSM states: IDLE, START, WAIT, OUT.
  - IDLE: `count`>0 → START.
  - START: `div_start`=1 for exactly this cycle → WAIT.
  - WAIT: `div_done`=1 → capture `div_res` and head tag into output registers, pop FIFO → OUT. Otherwise stay.
  - OUT: `out_valid`=1. On `out_ready`: `count`>0 → START, else IDLE.
- `div_done` is a level and is high while the divider is idle. It is ignored in IDLE, START and OUT.
- Sampling begins in the first WAIT cycle (the cycle after `div_start`). This covers both the divider's 1-cycle special-case completion and its long normal completion.
- `div_op_a`/`div_op_b` come from the FIFO head and are stable from START until capture. The divider reads operands combinationally throughout the operation.
- `out_res`/`out_tag` change only at capture.
- Only one operation is in flight. The divider is not restarted while OUT is stalled.
- Reset (any time, including mid-operation):
  - state → IDLE; `count`, pointers → 0.
  - `div_start`, `out_valid` → 0; `out_res`, `out_tag` → 0.
  - The in-flight request and queued requests are discarded.

## Timing
- Reset values: `in_ready`=1 once `count`=0, `div_start`=0, `div_op_a`/`div_op_b`=0, `out_valid`=0, `out_res`=0, `out_tag`=0, `count`=0, `busy`=0.
- Request accepted at cycle C from an empty, IDLE unit:
  - IDLE at C+1.
  - `div_start` at C+2 (cycle T).
  - WAIT from T+1.
- `div_done` first high in WAIT at cycle T+L (L≥1) → `out_valid` at T+L+1.
- Handshake at OUT cycle H with FIFO non-empty → next `div_start` at H+1.
- With `fp_div` DATA_W=32/EXP_W=8: L=57 for normal operands, L=1 for special cases.

## Test plan
- Idle divider model (`div_done`=1 constantly), single request a=0x40400000, b=0x3F800000, tag 3; model drops `div_done` at T+1 and returns 0x40400000 at T+5.
  - `div_start` at C+2.
  - `out_valid` at T+6 with `out_res`=0x40400000, `out_tag`=3.
  - The stale `div_done`=1 during the START cycle is not captured.
- Special case: model raises `div_done` at T+1 with 0x7FC00000.
  - `out_valid` at T+2, `out_res`=0x7FC00000.
- Push 6 requests back-to-back, DEPTH=4, tags 0-5, `out_ready`=1.
  - `in_ready` low while `count`=4.
  - Results return tags 0,1,2,3,4,5 in order.
  - `div_op_a`/`div_op_b` stable across each WAIT.
- `out_ready`=0 for 10 cycles with 2 requests queued.
  - `out_res`/`out_tag` held.
  - No `div_start` during the stall.
  - Next `div_start` one cycle after the handshake.
- Assert `rst` at T+3 of an operation with 2 queued.
  - All outputs take reset values immediately.
  - After release, no `div_start` until a new push.
  - First new result carries the new tag.
- Fill to full with a simultaneous pop: `in_ready` stays 0 in the pop cycle and `count` goes 4→3.
